// File: rtl/nfu_seq_ctrl.sv
// nfu_seq_ctrl: sequencer for one multiply-add neuron datapath in the NFU.
// It walks ni input pairs per neuron over nn neurons, issuing NBin/SB reads,
// forwarding the returned operands to the MAC, holding the partial sum, and
// presenting each finished neuron on a valid/ready result port.
module nfu_seq_ctrl #(
    parameter int N  = 16,
    parameter int AW = 10,
    parameter int CW = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_start,
    input  logic [CW-1:0] i_ni,
    input  logic [CW-1:0] i_nn,
    output logic          o_busy,
    output logic          o_rd_en,
    output logic [AW-1:0] o_nbin_addr,
    output logic [AW-1:0] o_sb_addr,
    input  logic [N-1:0]  i_nbin_data,
    input  logic [N-1:0]  i_sb_data,
    output logic [N-1:0]  o_mac_nbin,
    output logic [N-1:0]  o_mac_sb,
    output logic [N-1:0]  o_mac_nbout,
    input  logic [N-1:0]  i_mac_res,
    output logic          o_res_valid,
    input  logic          i_res_ready,
    output logic [N-1:0]  o_res,
    output logic [CW-1:0] o_res_idx,
    output logic          o_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_OUT,
        S_FIN
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] i_q, i_d;
    logic [CW-1:0] j_q, j_d;
    logic [CW-1:0] ni_q, ni_d;
    logic [CW-1:0] nn_q, nn_d;
    logic [AW-1:0] sb_base_q, sb_base_d;
    logic [N-1:0]  psum_q, psum_d;
    logic          data_vld_q, data_vld_d;
    logic          rd_en;
    logic          psum_clr;

    // State register and datapath registers; reset also drops any in-flight read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            i_q        <= '0;
            j_q        <= '0;
            ni_q       <= '0;
            nn_q       <= '0;
            sb_base_q  <= '0;
            psum_q     <= '0;
            data_vld_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            i_q        <= i_d;
            j_q        <= j_d;
            ni_q       <= ni_d;
            nn_q       <= nn_d;
            sb_base_q  <= sb_base_d;
            psum_q     <= psum_d;
            data_vld_q <= data_vld_d;
        end
    end

    // Next-state and counter update; shadows only load on a start taken in IDLE.
    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        j_d       = j_q;
        ni_d      = ni_q;
        nn_d      = nn_q;
        sb_base_d = sb_base_q;
        rd_en     = 1'b0;
        psum_clr  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    ni_d = i_ni;
                    nn_d = i_nn;
                    if (i_ni == '0 || i_nn == '0) begin
                        state_d = S_FIN;
                    end else begin
                        i_d       = '0;
                        j_d       = '0;
                        sb_base_d = '0;
                        psum_clr  = 1'b1;
                        state_d   = S_RUN;
                    end
                end
            end
            S_RUN: begin
                rd_en = 1'b1;
                i_d   = i_q + CW'(1);
                if (i_q == ni_q - CW'(1)) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Last operand pair lands this cycle; result is final next cycle.
                state_d = S_OUT;
            end
            S_OUT: begin
                if (i_res_ready) begin
                    if (j_q == nn_q - CW'(1)) begin
                        state_d = S_FIN;
                    end else begin
                        j_d       = j_q + CW'(1);
                        sb_base_d = sb_base_q + AW'(ni_q);
                        i_d       = '0;
                        psum_clr  = 1'b1;
                        state_d   = S_RUN;
                    end
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Accumulate returning MAC results; returning data always wins over a clear.
    always_comb begin
        data_vld_d = rd_en;
        psum_d     = psum_q;
        if (data_vld_q) begin
            psum_d = i_mac_res;
        end else if (psum_clr) begin
            psum_d = '0;
        end
    end

    // Operands are gated by the data-valid flag so they read as zero outside a
    // live read return (including straight after reset).
    assign o_busy      = (state_q != S_IDLE);
    assign o_rd_en     = rd_en;
    assign o_nbin_addr = AW'(i_q);
    assign o_sb_addr   = sb_base_q + AW'(i_q);
    assign o_mac_nbin  = data_vld_q ? i_nbin_data : '0;
    assign o_mac_sb    = data_vld_q ? i_sb_data : '0;
    assign o_mac_nbout = psum_q;
    assign o_res_valid = (state_q == S_OUT);
    assign o_res       = psum_q;
    assign o_res_idx   = j_q;
    assign o_done      = (state_q == S_FIN);

endmodule

// File: tb/tb_nfu_seq_ctrl.sv
// Bench for nfu_seq_ctrl: per-cycle vector tables plus hand-written sequences
// for backpressure, overflow/ignored restart and reset mid-run.
module tb_nfu_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [9:0]  ni, nn;
    logic        busy, rd_en, res_valid, ready, done;
    logic [9:0]  nbin_addr, sb_addr, res_idx;
    logic [15:0] nbin_d, sb_d, mac_nbin, mac_sb, mac_nbout, mac_res, res;

    logic [15:0] nbin_mem [0:15];
    logic [15:0] sb_mem   [0:15];

    int pass_cnt = 0;
    int total    = 0;

    always #5 clk = ~clk;

    nfu_seq_ctrl #(.N(16), .AW(10), .CW(10)) dut (
        .clk(clk), .rst(rst), .i_start(start), .i_ni(ni), .i_nn(nn),
        .o_busy(busy), .o_rd_en(rd_en), .o_nbin_addr(nbin_addr), .o_sb_addr(sb_addr),
        .i_nbin_data(nbin_d), .i_sb_data(sb_d),
        .o_mac_nbin(mac_nbin), .o_mac_sb(mac_sb), .o_mac_nbout(mac_nbout),
        .i_mac_res(mac_res), .o_res_valid(res_valid), .i_res_ready(ready),
        .o_res(res), .o_res_idx(res_idx), .o_done(done)
    );

    // Buffer model: one-cycle read latency; MAC model a*b+c with 16-bit wrap.
    always @(posedge clk) begin
        if (rd_en) begin
            nbin_d <= nbin_mem[nbin_addr[3:0]];
            sb_d   <= sb_mem[sb_addr[3:0]];
        end
    end
    assign mac_res = mac_nbin * mac_sb + mac_nbout;

    typedef struct {
        logic        st;
        logic [9:0]  ni, nn;
        logic        rdy;
        logic        rd;
        logic [9:0]  na, sa;
        logic        cnb;
        logic [15:0] nb;
        logic        vld;
        logic [15:0] res;
        logic [9:0]  idx;
        logic        done;
        logic        busy;
    } vec_t;

    vec_t tv [0:24];

    function automatic vec_t v(int st, int vni, int vnn, int rd, int na, int sa,
                               int cnb, int nb, int vld, int r, int idx, int dn, int bs);
        vec_t t;
        t.st = 1'(st); t.ni = 10'(vni); t.nn = 10'(vnn); t.rdy = 1'b1;
        t.rd = 1'(rd); t.na = 10'(na); t.sa = 10'(sa);
        t.cnb = 1'(cnb); t.nb = 16'(nb);
        t.vld = 1'(vld); t.res = 16'(r); t.idx = 10'(idx);
        t.done = 1'(dn); t.busy = 1'(bs);
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h want %0h", name, act, exp);
        else pass_cnt++;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " busy"}, 32'(busy), 0);
        chk({tag, " rd_en"}, 32'(rd_en), 0);
        chk({tag, " valid"}, 32'(res_valid), 0);
        chk({tag, " done"}, 32'(done), 0);
        chk({tag, " addrs"}, {12'(nbin_addr), 10'(sb_addr), res_idx}, 0);
        chk({tag, " data"}, {res, mac_nbout}, 0);
        chk({tag, " mac_ops"}, {mac_nbin, mac_sb}, 0);
    endtask

    task automatic run_table(input int lo, input int hi, input string tag);
        for (int k = lo; k <= hi; k++) begin
            @(negedge clk);
            start = tv[k].st; ni = tv[k].ni; nn = tv[k].nn; ready = tv[k].rdy;
            #1;
            chk($sformatf("%s[%0d] rd_en", tag, k - lo), 32'(rd_en), 32'(tv[k].rd));
            if (tv[k].rd)
                chk($sformatf("%s[%0d] addrs", tag, k - lo), {nbin_addr, sb_addr},
                    {tv[k].na, tv[k].sa});
            if (tv[k].cnb)
                chk($sformatf("%s[%0d] nbout", tag, k - lo), 32'(mac_nbout), 32'(tv[k].nb));
            chk($sformatf("%s[%0d] valid", tag, k - lo), 32'(res_valid), 32'(tv[k].vld));
            if (tv[k].vld)
                chk($sformatf("%s[%0d] res/idx", tag, k - lo), {res, 6'(0), res_idx},
                    {tv[k].res, 6'(0), tv[k].idx});
            chk($sformatf("%s[%0d] done/busy", tag, k - lo), {done, busy},
                {tv[k].done, tv[k].busy});
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic load_single();
        for (int a = 0; a < 16; a++) begin nbin_mem[a] = 16'hdead; sb_mem[a] = 16'hbeef; end
        nbin_mem[0] = 1; nbin_mem[1] = 2; nbin_mem[2] = 3;
        sb_mem[0] = 4; sb_mem[1] = 5; sb_mem[2] = 6;
    endtask

    task automatic load_two();
        for (int a = 0; a < 16; a++) begin nbin_mem[a] = 16'hdead; sb_mem[a] = 16'hbeef; end
        nbin_mem[0] = 2; nbin_mem[1] = 3;
        sb_mem[0] = 1; sb_mem[1] = 1; sb_mem[2] = 10; sb_mem[3] = 20;
    endtask

    initial begin
        int cnt, rd_cnt, res_cnt, done_cnt;
        logic [15:0] last_res;
        logic [9:0]  last_idx;
        logic        got;

        // Single neuron ni=3 nn=1; ni/nn wiggle after start must not matter.
        tv[0]  = v(1, 3, 1, 0, 0, 0, 0,  0, 0,  0, 0, 0, 0);
        tv[1]  = v(0, 7, 5, 1, 0, 0, 1,  0, 0,  0, 0, 0, 1);
        tv[2]  = v(0, 7, 5, 1, 1, 1, 1,  0, 0,  0, 0, 0, 1);
        tv[3]  = v(0, 0, 0, 1, 2, 2, 1,  4, 0,  0, 0, 0, 1);
        tv[4]  = v(0, 0, 0, 0, 0, 0, 1, 14, 0,  0, 0, 0, 1);
        tv[5]  = v(0, 0, 0, 0, 0, 0, 1, 32, 1, 32, 0, 0, 1);
        tv[6]  = v(0, 0, 0, 0, 0, 0, 1, 32, 0,  0, 0, 1, 1);
        tv[7]  = v(0, 0, 0, 0, 0, 0, 0,  0, 0,  0, 0, 0, 0);
        // Two neurons ni=2 nn=2: SB 0,1 then 2,3; psum cleared between neurons.
        tv[8]  = v(1, 2, 2, 0, 0, 0, 0,  0, 0,  0, 0, 0, 0);
        tv[9]  = v(0, 1, 1, 1, 0, 0, 1,  0, 0,  0, 0, 0, 1);
        tv[10] = v(0, 1, 1, 1, 1, 1, 1,  0, 0,  0, 0, 0, 1);
        tv[11] = v(0, 1, 1, 0, 0, 0, 1,  2, 0,  0, 0, 0, 1);
        tv[12] = v(0, 1, 1, 0, 0, 0, 1,  5, 1,  5, 0, 0, 1);
        tv[13] = v(0, 1, 1, 1, 0, 2, 1,  0, 0,  0, 0, 0, 1);
        tv[14] = v(0, 1, 1, 1, 1, 3, 1,  0, 0,  0, 0, 0, 1);
        tv[15] = v(0, 1, 1, 0, 0, 0, 1, 20, 0,  0, 0, 0, 1);
        tv[16] = v(0, 1, 1, 0, 0, 0, 1, 80, 1, 80, 1, 0, 1);
        tv[17] = v(0, 1, 1, 0, 0, 0, 1, 80, 0,  0, 0, 1, 1);
        tv[18] = v(0, 1, 1, 0, 0, 0, 0,  0, 0,  0, 0, 0, 0);
        // Degenerate: ni=0 then nn=0 -> done next cycle, no reads, no results.
        tv[19] = v(1, 0, 3, 0, 0, 0, 0,  0, 0,  0, 0, 0, 0);
        tv[20] = v(0, 0, 3, 0, 0, 0, 0,  0, 0,  0, 0, 1, 1);
        tv[21] = v(0, 0, 3, 0, 0, 0, 0,  0, 0,  0, 0, 0, 0);
        tv[22] = v(1, 3, 0, 0, 0, 0, 0,  0, 0,  0, 0, 0, 0);
        tv[23] = v(0, 3, 0, 0, 0, 0, 0,  0, 0,  0, 0, 1, 1);
        tv[24] = v(0, 3, 0, 0, 0, 0, 0,  0, 0,  0, 0, 0, 0);

        rst = 1'b1; start = 1'b0; ni = '0; nn = '0; ready = 1'b1;
        nbin_d = '0; sb_d = '0;
        load_single();
        repeat (2) @(negedge clk);
        #1 chk_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        run_table(0, 7, "single");
        load_two();
        run_table(8, 18, "two");
        run_table(19, 24, "degen");

        // Backpressure: ready low for 6 cycles while the result is offered.
        load_single();
        ready = 1'b0; ni = 3; nn = 1;
        @(negedge clk); start = 1'b1;
        cnt = 0; got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk); start = 1'b0; cnt++;
            #1 if (res_valid) got = 1'b1;
        end
        chk("bp valid latency", 32'(cnt), 5);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk); #1;
            chk("bp hold", {res_valid, rd_en, res, 6'(0), res_idx}, {1'b1, 1'b0, 16'd32, 16'd0});
        end
        @(negedge clk); ready = 1'b1; #1;
        chk("bp accept valid", 32'(res_valid), 1);
        @(negedge clk); #1;
        chk("bp done after accept", {done, res_valid}, {1'b1, 1'b0});
        @(negedge clk); #1;
        chk("bp back idle", 32'(busy), 0);

        // Overflow plus ignored restart: 0x4000*8 twice wraps to 0.
        for (int a = 0; a < 2; a++) begin nbin_mem[a] = 16'h4000; sb_mem[a] = 16'h0008; end
        ni = 2; nn = 1; ready = 1'b1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b1; ni = 5; nn = 3;
        rd_cnt = 0; res_cnt = 0; done_cnt = 0; last_res = 16'hffff; last_idx = '1;
        #1 if (rd_en) rd_cnt++;
        for (int c = 0; c < 30 && done_cnt == 0; c++) begin
            @(negedge clk); start = 1'b0; #1;
            if (rd_en) rd_cnt++;
            if (res_valid) begin res_cnt++; last_res = res; last_idx = res_idx; end
            if (done) done_cnt++;
        end
        chk("ovf read count", 32'(rd_cnt), 2);
        chk("ovf result count", 32'(res_cnt), 1);
        chk("ovf result wrap", {last_res, 6'(0), last_idx}, 0);
        chk("ovf done seen", 32'(done_cnt), 1);
        @(negedge clk); #1;
        chk("ovf back idle", 32'(busy), 0);

        // Reset during RUN of neuron 1, then a fresh single-neuron run.
        load_two();
        run_table(8, 13, "pre_rst");
        #2 rst = 1'b1;
        #1 chk_zero("mid reset");
        @(negedge clk); rst = 1'b0;
        load_single();
        run_table(0, 7, "after_rst");

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
